// File: rtl/query_result_collector.sv
// query_result_collector
//   Closes one record per query from the per-target score stream and buffers
//   the records in a small FIFO drained through a valid/ready handshake, so
//   host back-pressure never stalls the upstream array.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   valid_i         one target's score is valid this cycle (counted)
//   result_i        per-target score, informational only
//   max_result_i    running best score of the current query
//   match_idx_i     target index of that best score
//   change_q_i      1-cycle end-of-query pulse (closes the record)
//   threshold_i     hit threshold, quasi-static
//   out_valid_o     head record available
//   out_ready_i     consumer accepts head record
//   q_id_o, score_o, idx_o, t_count_o, hit_o   head record payload
//   overflow_o      sticky: a record was dropped because the FIFO was full

`ifndef CALC_BIT
`define CALC_BIT 16
`endif
`ifndef MAX_T_NUM_BIT
`define MAX_T_NUM_BIT 8
`endif

module query_result_collector #(
  parameter int SCORE_W = `CALC_BIT,
  parameter int IDX_W   = `MAX_T_NUM_BIT,
  parameter int QID_W   = 8,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic [SCORE_W-1:0] result_i,
  input  logic [SCORE_W-1:0] max_result_i,
  input  logic [IDX_W-1:0]   match_idx_i,
  input  logic               change_q_i,
  input  logic [SCORE_W-1:0] threshold_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [QID_W-1:0]   q_id_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic [IDX_W:0]     t_count_o,
  output logic               hit_o,
  output logic               overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = IDX_W + 1;

  localparam logic [CW-1:0]    CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [QID_W-1:0] QID_ONE = {{(QID_W-1){1'b0}}, 1'b1};
  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Target counter holds at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (&v) return v;
    return v + CNT_ONE;
  endfunction

  // The per-target score is not part of the record.
  logic unused_result;
  assign unused_result = ^result_i;

  logic [CW-1:0]    t_cnt_p0;
  logic [QID_W-1:0] qid_p0;
  logic [AW:0]      wr_ptr_p1;
  logic [AW:0]      rd_ptr_p1;
  logic             overflow_p1;

  logic [QID_W-1:0]   qid_mem_p1   [DEPTH];
  logic [SCORE_W-1:0] score_mem_p1 [DEPTH];
  logic [IDX_W-1:0]   idx_mem_p1   [DEPTH];
  logic [CW-1:0]      cnt_mem_p1   [DEPTH];
  logic               hit_mem_p1   [DEPTH];

  logic empty;
  logic full;
  logic pop;
  logic vld_p0;
  logic hit_p0;

  assign empty  = (wr_ptr_p1 == rd_ptr_p1);
  // Same slot, opposite wrap bit: every entry is occupied.
  assign full   = (wr_ptr_p1[AW] != rd_ptr_p1[AW]) &&
                  (wr_ptr_p1[AW-1:0] == rd_ptr_p1[AW-1:0]);
  assign pop    = !empty && out_ready_i;
  // A pop at the same edge frees the head slot, so a full FIFO still accepts.
  assign vld_p0 = change_q_i && (!full || pop);
  assign hit_p0 = (max_result_i >= threshold_i);

  // ---- stage p0: per-query counting and close ----
  always_ff @(posedge clk) begin
    if (rst) begin
      t_cnt_p0 <= '0;
      qid_p0   <= '0;
    end else if (change_q_i) begin
      t_cnt_p0 <= '0;
      qid_p0   <= qid_p0 + QID_ONE;
    end else if (valid_i) begin
      t_cnt_p0 <= sat_inc(t_cnt_p0);
    end
  end

  // ---- stage p1: record FIFO ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_p1   <= '0;
      rd_ptr_p1   <= '0;
      overflow_p1 <= 1'b0;
    end else begin
      if (vld_p0) wr_ptr_p1 <= wr_ptr_p1 + PTR_ONE;
      if (pop)    rd_ptr_p1 <= rd_ptr_p1 + PTR_ONE;
      if (change_q_i && !vld_p0) overflow_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && vld_p0) begin
      qid_mem_p1[wr_ptr_p1[AW-1:0]]   <= qid_p0;
      score_mem_p1[wr_ptr_p1[AW-1:0]] <= max_result_i;
      idx_mem_p1[wr_ptr_p1[AW-1:0]]   <= match_idx_i;
      cnt_mem_p1[wr_ptr_p1[AW-1:0]]   <= t_cnt_p0;
      hit_mem_p1[wr_ptr_p1[AW-1:0]]   <= hit_p0;
    end
  end

  // ---- output: head entry, forced to zero while empty ----
  always_comb begin
    q_id_o    = '0;
    score_o   = '0;
    idx_o     = '0;
    t_count_o = '0;
    hit_o     = 1'b0;
    if (!empty) begin
      q_id_o    = qid_mem_p1[rd_ptr_p1[AW-1:0]];
      score_o   = score_mem_p1[rd_ptr_p1[AW-1:0]];
      idx_o     = idx_mem_p1[rd_ptr_p1[AW-1:0]];
      t_count_o = cnt_mem_p1[rd_ptr_p1[AW-1:0]];
      hit_o     = hit_mem_p1[rd_ptr_p1[AW-1:0]];
    end
  end

  assign out_valid_o = !empty;
  assign overflow_o  = overflow_p1;

endmodule

// File: doc/query_result_collector.md
# query_result_collector

Downstream of the per-target output parser. Consumes its registered per-target score stream and end-of-query pulse, and closes one record per query: final best score, best-target index, target count, threshold-hit flag and a wrapping query ID. Records are buffered in a small FIFO and drained to the host/DMA side through a valid/ready handshake, so host back-pressure never stalls the systolic array.

## Interface

Parameters:
- SCORE_W, default `CALC_BIT: score width.
- IDX_W, default `MAX_T_NUM_BIT: target-index width.
- QID_W, default 8: query ID width; wraps.
- DEPTH, default 4: FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- valid_i  in  1  one target's score is valid this cycle.
- result_i  in  SCORE_W  per-target score; informational only, not stored.
- max_result_i  in  SCORE_W  running best score of the current query.
- match_idx_i  in  IDX_W  target index of that best score.
- change_q_i  in  1  1-cycle end-of-query pulse; max_result_i and match_idx_i hold that query's final values in this same cycle.
- threshold_i  in  SCORE_W  hit threshold; quasi-static.
- out_valid_o  out  1  record available.
- out_ready_i  in  1  consumer accepts the record.
- q_id_o  out  QID_W  query ID of the head record.
- score_o  out  SCORE_W  final best score.
- idx_o  out  IDX_W  best-target index.
- t_count_o  out  IDX_W+1  number of targets counted for the query.
- hit_o  out  1  score_o ≥ threshold_i, unsigned, sampled at close.
- overflow_o  out  1  sticky: a record was dropped.

## Operation

**Target counter** (IDX_W+1 bits)
- Increments by 1 on each valid_i with change_q_i low.
- Saturates at all-ones.
- On change_q_i it is loaded to 0. A valid_i in the same cycle is counted in neither query.

**Query close** (change_q_i = 1)
- Forms the record {qid, max_result_i, match_idx_i, counter value before reset, max_result_i ≥ threshold_i}.
- qid is the internal query counter. It increments by 1 on every change_q_i, including dropped ones, and wraps from 2^QID_W−1 to 0.

**FIFO**
- DEPTH entries, read and write pointers of log2(DEPTH)+1 bits, output fields taken from the head entry.
- Push occurs when change_q_i is high and (not full, or a pop happens in the same cycle).
- If change_q_i is high while full and no pop happens, the record is dropped, overflow_o is set, and FIFO contents are unchanged.
- Pop occurs when out_valid_o & out_ready_i.
- Push and pop in the same cycle leave occupancy unchanged. Order is strictly FIFO.

**Outputs**
- out_valid_o = FIFO not empty.
- Payload outputs hold their value while out_valid_o & ~out_ready_i.
- overflow_o is cleared only by rst.

**Reset**
- Clears the pointers, target counter, query counter and overflow_o.
- All outputs are 0 after the reset edge. Payload outputs are 0 when empty.
- Reset asserted mid-stream discards all buffered records and any partially counted query.
- Inputs are ignored in any cycle where rst = 1.

## Timing

- Close-to-output latency is 1 cycle. change_q_i sampled at edge N with the FIFO empty gives out_valid_o = 1 and a valid payload in the cycle after edge N.
- A pop at edge M exposes the next record, or deasserts out_valid_o, in the cycle after M.
- Back-to-back change_q_i on consecutive cycles are supported: one push per cycle.
- Full-while-popping: a push and a pop at the same edge both succeed.
- No combinational path from out_ready_i to out_valid_o or to any payload output.
- No input-to-output combinational paths.

## Test plan

- **Single query.** After reset, 5 valid_i pulses, then change_q_i with max_result_i = 37, match_idx_i = 2, threshold_i = 30, out_ready_i = 1.
  Expect one cycle later: out_valid_o = 1, q_id_o = 0, score_o = 37, idx_o = 2, t_count_o = 5, hit_o = 1. Popped at the next edge.
- **Back-pressure and order.** out_ready_i = 0; close 3 queries with scores 10, 20, 30.
  Expect out_valid_o held and payload stable. Raising out_ready_i drains q_id 0, 1, 2 in order with scores 10, 20, 30.
- **Overflow.** DEPTH = 4, out_ready_i = 0, 5 closes.
  Expect overflow_o = 1 after the 5th, the FIFO still holding q_id 0..3, and the next close carrying q_id 5.
- **Full with simultaneous pop.** FIFO full, out_ready_i = 1 and change_q_i in the same cycle.
  Expect no overflow, occupancy still 4, and the new record at the tail.
- **Coincident valid.** valid_i and change_q_i high in the same cycle after 3 prior valid_i pulses.
  Expect t_count_o = 3 for the closed query and 0 for the next query if no further valid_i arrives.
- **Reset mid-operation.** 2 records buffered and overflow_o set; assert rst for one cycle.
  Expect all outputs 0 and the next close to carry q_id 0.
